// File: rtl/photo_event_gen.sv
// photo_event_gen: sensor front end for the queue counter.
// Conditions two raw active-low photo-sensor inputs (0 = beam broken).
// Each input is synchronised, debounced by a small FSM, and turned into
// exactly one single-cycle strobe per beam break.
//
// Ports:
//   clk           system clock, rising edge
//   rest          synchronous active-high reset
//   backphoto     raw back sensor, asynchronous, active-low
//   forwardphoto  raw forward sensor, asynchronous, active-low
//   arrive_pulse  1-cycle strobe per debounced back-beam break ("customer joined")
//   depart_pulse  1-cycle strobe per debounced forward-beam break ("customer served")
//   back_fault    back beam stuck broken (0 unless PHOTO_STUCK_DETECT_EN)
//   fwd_fault     forward beam stuck broken (0 unless PHOTO_STUCK_DETECT_EN)
//
// Optional feature: define PHOTO_STUCK_DETECT_EN to build the stuck-beam detectors.
module photo_event_gen #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rest,
  input  logic backphoto,
  input  logic forwardphoto,
  output logic arrive_pulse,
  output logic depart_pulse,
  output logic back_fault,
  output logic fwd_fault
);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_param
    $error("photo_event_gen: illegal parameter value");
  end

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_CYCLES);

  typedef enum logic [1:0] {StClear, StFallWait, StBlocked, StRiseWait} state_e;

  // Index 0 = back sensor, index 1 = forward sensor.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q  [2];
  logic [SYNC_STAGES-1:0] sync_d  [2];
  state_e                 state_q [2];
  state_e                 state_d [2];
  logic [CntW-1:0]        cnt_q   [2];
  logic [CntW-1:0]        cnt_d   [2];
  logic [1:0]             evt_q, evt_d;
  logic                   pend_q, pend_d;
  logic                   arrive_q, arrive_d;
  logic                   depart_q, depart_d;

  assign raw = {forwardphoto, backphoto};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      evt_d[i]   = 1'b0;
      unique case (state_q[i])
        StClear: begin
          if (!sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = StFallWait;
            cnt_d[i]   = CntW'(1);
          end
        end
        StFallWait: begin
          if (sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = StClear;
          end else if (cnt_q[i] == DebMax) begin
            state_d[i] = StBlocked;
            evt_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StBlocked: begin
          if (sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = StRiseWait;
            cnt_d[i]   = CntW'(1);
          end
        end
        StRiseWait: begin
          if (!sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = StBlocked;
          end else if (cnt_q[i] == DebMax) begin
            state_d[i] = StClear;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: state_d[i] = StClear;
      endcase
    end
  end

  // Arrive wins a simultaneous event; depart is deferred one cycle. A fresh back
  // event cannot coincide with the pending depart since debounce takes many cycles.
  always_comb begin
    arrive_d = evt_q[0];
    depart_d = pend_q | (evt_q[1] & ~evt_q[0]);
    pend_d   = evt_q[1] & evt_q[0];
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= '1;
        state_q[i] <= StClear;
        cnt_q[i]   <= '0;
      end
      evt_q    <= '0;
      pend_q   <= 1'b0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      evt_q    <= evt_d;
      pend_q   <= pend_d;
      arrive_q <= arrive_d;
      depart_q <= depart_d;
    end
  end

  assign arrive_pulse = arrive_q;
  assign depart_pulse = depart_q;

`ifdef PHOTO_STUCK_DETECT_EN
  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic [StuckW-1:0] stuck_q [2];
  logic [StuckW-1:0] stuck_d [2];
  logic [1:0]        fault_q, fault_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stuck_d[i] = stuck_q[i];
      fault_d[i] = fault_q[i];
      if (state_d[i] == StClear) begin
        // Returning to CLEAR releases the fault and the count on the same edge.
        stuck_d[i] = '0;
        fault_d[i] = 1'b0;
      end else if (state_q[i] == StBlocked && stuck_q[i] != StuckMax) begin
        stuck_d[i] = stuck_q[i] + StuckW'(1);
      end
      if (state_d[i] != StClear && stuck_d[i] == StuckMax) begin
        fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < 2; i++) begin
        stuck_q[i] <= '0;
      end
      fault_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        stuck_q[i] <= stuck_d[i];
      end
      fault_q <= fault_d;
    end
  end

  assign back_fault = fault_q[0];
  assign fwd_fault  = fault_q[1];
`else
  assign back_fault = 1'b0;
  assign fwd_fault  = 1'b0;
`endif

endmodule
